alu_result_sequencer: RTL and testbench

//  Parametrised, sequential successor to the ALU output controller. Latches one operation (AND/OR/ADD/SUB), drives operands
//  and ADD_SUB_SEL to the external logic and add/sub units, waits a configurable add/sub latency, then captures the selected

---
 rtl/alu_result_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_result_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_sequencer.sv
// rtl/alu_result_sequencer.sv - sequential ALU result sequencer with valid/ready handshake
//
// Purpose:
//    Latches one operation (AND/OR/ADD/SUB) and registers its operands for the
//    external logic and add/sub units. For ADD/SUB it waits ADD_LAT cycles before
//    capturing the result. It then presents the captured result under a
//    valid/ready handshake. A captured result can be fed back as operand A
//    (accumulate).
//
// Optional feature (macro ALU_FLAGS_EN):
//    defined   - Zero/Negative are registered from the captured value
//    undefined - Zero/Negative are tied to 0 and no flag registers exist
//
// Ports:
//    Clk, Rst                       clock, synchronous active-high reset
//    In_Valid/In_Ready              request handshake
//    Control, A_In, B_In, Acc_Sel   op select, operands, accumulate select
//    Op_A, Op_B, ADD_SUB_SEL        registered operands/op to external units
//    ADD_SUB_In, ADD_SUB_Cout       external add/sub result and carry
//    OR_In, AND_In                  external logic unit results
//    Out_Valid/Out_Ready            result handshake
//    nBitOut, Carry_Out             captured result and carry
//    Zero, Negative                 status flags

module alu_result_sequencer #(
   parameter int WIDTH   = 16,
   parameter int ADD_LAT = 1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [1:0]       Control,
   input  logic [WIDTH-1:0] A_In,
   input  logic [WIDTH-1:0] B_In,
   input  logic             Acc_Sel,
   output logic [WIDTH-1:0] Op_A,
   output logic [WIDTH-1:0] Op_B,
   output logic             ADD_SUB_SEL,
   input  logic [WIDTH-1:0] ADD_SUB_In,
   input  logic             ADD_SUB_Cout,
   input  logic [WIDTH-1:0] OR_In,
   input  logic [WIDTH-1:0] AND_In,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] nBitOut,
   output logic             Carry_Out,
   output logic             Zero,
   output logic             Negative
);

   localparam logic [3:0] LP_LAT = ADD_LAT[3:0];

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_capture;
   logic             w_accept;
   logic [WIDTH-1:0] w_sel_result;

   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [1:0]       r_op;
   logic             r_add_sub_sel;
   logic [3:0]       r_cnt;
   // Doubles as the accumulator: both are loaded with the same value at capture
   // and both clear on reset, so one register serves both roles.
   logic [WIDTH-1:0] r_result;
   logic             r_carry;

   always_ff @(posedge Clk) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (In_Valid) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (r_cnt == 4'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            w_out_valid = 1'b1;
            w_in_ready  = Out_Ready;
            if (Out_Ready) w_state_nxt = In_Valid ? S_EXEC : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = In_Valid & w_in_ready;

   always_comb begin
      w_sel_result = ADD_SUB_In;
      case (r_op)
         2'b00:   w_sel_result = AND_In;
         2'b01:   w_sel_result = OR_In;
         default: w_sel_result = ADD_SUB_In;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_op          <= 2'b00;
         r_add_sub_sel <= 1'b0;
         r_cnt         <= 4'd0;
         r_result      <= '0;
         r_carry       <= 1'b0;
      end else begin
         if (w_accept) begin
            // In a back-to-back accept from HOLD, r_result is still the value
            // being handed off, which is exactly the accumulate operand wanted.
            r_op_a        <= Acc_Sel ? r_result : A_In;
            r_op_b        <= B_In;
            r_op          <= Control;
            r_add_sub_sel <= Control[1] & Control[0];
            r_cnt         <= Control[1] ? LP_LAT : 4'd0;
         end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_result <= w_sel_result;
            r_carry  <= r_op[1] & ADD_SUB_Cout;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   logic r_zero;
   logic r_negative;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_zero     <= 1'b0;
         r_negative <= 1'b0;
      end else if (w_capture) begin
         r_zero     <= (w_sel_result == '0);
         r_negative <= w_sel_result[WIDTH-1];
      end
   end

   assign Zero     = r_zero;
   assign Negative = r_negative;
`else
   assign Zero     = 1'b0;
   assign Negative = 1'b0;
`endif

   assign In_Ready    = w_in_ready;
   assign Out_Valid   = w_out_valid;
   assign Op_A        = r_op_a;
   assign Op_B        = r_op_b;
   assign ADD_SUB_SEL = r_add_sub_sel;
   assign nBitOut     = r_result;
   assign Carry_Out   = r_carry;

endmodule

// File: tb/tb_alu_result_sequencer.sv
// tb/tb_alu_result_sequencer.sv - directed self-checking bench for alu_result_sequencer
module tb_alu_result_sequencer;

   localparam int WIDTH = 16;

   logic             Clk = 1'b0;
   logic             Rst;
   logic             In_Valid;
   logic             In_Ready;
   logic [1:0]       Control;
   logic [WIDTH-1:0] A_In;
   logic [WIDTH-1:0] B_In;
   logic             Acc_Sel;
   logic [WIDTH-1:0] Op_A;
   logic [WIDTH-1:0] Op_B;
   logic             ADD_SUB_SEL;
   logic [WIDTH-1:0] ADD_SUB_In;
   logic             ADD_SUB_Cout;
   logic [WIDTH-1:0] OR_In;
   logic [WIDTH-1:0] AND_In;
   logic             Out_Valid;
   logic             Out_Ready;
   logic [WIDTH-1:0] nBitOut;
   logic             Carry_Out;
   logic             Zero;
   logic             Negative;

   int n_cmp = 0;
   int n_err = 0;

`ifdef ALU_FLAGS_EN
   localparam logic FLAG_ON = 1'b1;
`else
   localparam logic FLAG_ON = 1'b0;
`endif

   always #5 Clk = ~Clk;

   // External units, combinational from the registered operands.
   logic [WIDTH:0] w_ext;
   assign w_ext        = ADD_SUB_SEL ? ({1'b0, Op_A} + {1'b0, ~Op_B} + 17'd1)
                                     : ({1'b0, Op_A} + {1'b0, Op_B});
   assign ADD_SUB_In   = w_ext[WIDTH-1:0];
   assign ADD_SUB_Cout = w_ext[WIDTH];
   assign OR_In        = Op_A | Op_B;
   assign AND_In       = Op_A & Op_B;

   alu_result_sequencer #(.WIDTH(WIDTH), .ADD_LAT(2)) dut (
      .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .Control(Control), .A_In(A_In), .B_In(B_In), .Acc_Sel(Acc_Sel),
      .Op_A(Op_A), .Op_B(Op_B), .ADD_SUB_SEL(ADD_SUB_SEL),
      .ADD_SUB_In(ADD_SUB_In), .ADD_SUB_Cout(ADD_SUB_Cout),
      .OR_In(OR_In), .AND_In(AND_In), .Out_Valid(Out_Valid),
      .Out_Ready(Out_Ready), .nBitOut(nBitOut), .Carry_Out(Carry_Out),
      .Zero(Zero), .Negative(Negative)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_op(input logic [1:0] ctl, input logic [15:0] a,
                           input logic [15:0] b, input logic acc);
      In_Valid = 1'b1;
      Control  = ctl;
      A_In     = a;
      B_In     = b;
      Acc_Sel  = acc;
   endtask

   task automatic release_in();
      In_Valid = 1'b0;
      Acc_Sel  = 1'b0;
      Out_Ready = 1'b0;
   endtask

   initial begin
      Rst = 1'b1; In_Valid = 1'b0; Control = 2'b00; A_In = '0; B_In = '0;
      Acc_Sel = 1'b0; Out_Ready = 1'b0;
      step(); step();
      check_eq("rst_out_valid", Out_Valid, 0);
      check_eq("rst_nbitout", nBitOut, 16'h0000);
      check_eq("rst_sel", ADD_SUB_SEL, 0);
      check_eq("rst_opa", Op_A, 16'h0000);
      check_eq("rst_carry", Carry_Out, 0);
      check_eq("rst_zero", Zero, 0);
      Rst = 1'b0;
      step();
      check_eq("rst_in_ready", In_Ready, 1);

      // 1: AND, one edge to result
      drive_op(2'b00, 16'hF0F0, 16'hFF00, 1'b0);
      step(); release_in();
      check_eq("and_exec_valid", Out_Valid, 0);
      check_eq("and_exec_ready", In_Ready, 0);
      check_eq("and_sel", ADD_SUB_SEL, 0);
      step();
      check_eq("and_valid", Out_Valid, 1);
      check_eq("and_result", nBitOut, 16'hF000);
      check_eq("and_carry", Carry_Out, 0);
      check_eq("and_neg", Negative, FLAG_ON);
      Out_Ready = 1'b1;
      step(); Out_Ready = 1'b0;
      check_eq("and_done_valid", Out_Valid, 0);
      check_eq("and_done_ready", In_Ready, 1);
      check_eq("and_opa_kept", Op_A, 16'hF0F0);

      // 2: SUB, three edges to result; Control changes in EXEC are ignored
      drive_op(2'b11, 16'h0005, 16'h0003, 1'b0);
      step(); release_in();
      Control = 2'b00; A_In = 16'h1234;
      check_eq("sub_sel", ADD_SUB_SEL, 1);
      check_eq("sub_e1_valid", Out_Valid, 0);
      step();
      check_eq("sub_e2_valid", Out_Valid, 0);
      step();
      check_eq("sub_e3_valid", Out_Valid, 0);
      step();
      check_eq("sub_valid", Out_Valid, 1);
      check_eq("sub_result", nBitOut, 16'h0002);
      check_eq("sub_carry", Carry_Out, 1);

      // 3: backpressure then back-to-back OR
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("bp_result", nBitOut, 16'h0002);
         check_eq("bp_in_ready", In_Ready, 0);
         check_eq("bp_valid", Out_Valid, 1);
      end
      Out_Ready = 1'b1;
      drive_op(2'b01, 16'h00F0, 16'h0F00, 1'b0);
      #1;
      check_eq("b2b_in_ready", In_Ready, 1);
      step(); release_in();
      check_eq("b2b_valid_drop", Out_Valid, 0);
      check_eq("b2b_opa", Op_A, 16'h00F0);
      check_eq("b2b_sel", ADD_SUB_SEL, 0);
      step();
      check_eq("or_valid", Out_Valid, 1);
      check_eq("or_result", nBitOut, 16'h0FF0);
      check_eq("or_carry", Carry_Out, 0);

      // 4: accumulate, both ops issued back-to-back from HOLD
      Out_Ready = 1'b1;
      drive_op(2'b10, 16'h0001, 16'h0001, 1'b0);
      step(); release_in();
      step(); step(); step();
      check_eq("acc1_valid", Out_Valid, 1);
      check_eq("acc1_result", nBitOut, 16'h0002);
      check_eq("acc1_carry", Carry_Out, 0);
      Out_Ready = 1'b1;
      drive_op(2'b10, 16'hFFFF, 16'h0003, 1'b1);
      step(); release_in();
      check_eq("acc2_opa", Op_A, 16'h0002);
      check_eq("acc2_opb", Op_B, 16'h0003);
      step(); step(); step();
      check_eq("acc2_valid", Out_Valid, 1);
      check_eq("acc2_result", nBitOut, 16'h0005);
      Out_Ready = 1'b1;
      step(); Out_Ready = 1'b0;
      check_eq("acc2_done", Out_Valid, 0);

      // 5: reset mid-EXEC aborts the ADD
      drive_op(2'b10, 16'h0010, 16'h0020, 1'b0);
      step(); release_in();
      step();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      check_eq("rx_valid", Out_Valid, 0);
      check_eq("rx_result", nBitOut, 16'h0000);
      check_eq("rx_sel", ADD_SUB_SEL, 0);
      check_eq("rx_in_ready", In_Ready, 1);
      check_eq("rx_opa", Op_A, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("rx_no_valid", Out_Valid, 0);
      end

      // 6: flags
      drive_op(2'b01, 16'h0000, 16'h0000, 1'b0);
      step(); release_in();
      step();
      check_eq("flz_valid", Out_Valid, 1);
      check_eq("flz_result", nBitOut, 16'h0000);
      check_eq("flz_zero", Zero, FLAG_ON);
      check_eq("flz_neg", Negative, 0);
      Out_Ready = 1'b1;
      step(); Out_Ready = 1'b0;
      drive_op(2'b00, 16'h8000, 16'hFFFF, 1'b0);
      step(); release_in();
      step();
      check_eq("fln_result", nBitOut, 16'h8000);
      check_eq("fln_neg", Negative, FLAG_ON);
      check_eq("fln_zero", Zero, 0);
      check_eq("fln_carry", Carry_Out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
